// File: rtl/rom_pkg.sv
// Shared constants for the ROM burst arbiter: parameter defaults, FSM encoding,
// requester IDs and the constant-table fill pattern.
package rom_pkg;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;

  localparam logic IDLE  = 1'b0;
  localparam logic BURST = 1'b1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Table word i is 0x11 * (i + 1); callers truncate to their word width.
  function automatic logic [31:0] rom_word(input int unsigned idx);
    return 32'h0000_0011 * (idx + 32'd1);
  endfunction

endpackage

// File: rtl/rom_burst_arbiter_rom.sv
// Small constant-table ROM with a combinational read port.
module rom
  import rom_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    assign mem[i] = DATA_WIDTH'(rom_word(i));
  end

  // Addresses beyond the populated depth read as zero.
  if (DEPTH < 2**ADDR_WIDTH) begin : g_partial
    assign data = (addr < ADDR_WIDTH'(DEPTH)) ? mem[addr] : '0;
  end else begin : g_full
    assign data = mem[addr];
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter sharing one ROM between two burst requesters; streams the
// words out on a registered valid/ready interface tagged with the owner ID.
module rom_burst_arbiter
  import rom_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] start_addr0,
  input  logic [ADDR_WIDTH-1:0] len0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] start_addr1,
  input  logic [ADDR_WIDTH-1:0] len1,
  output logic [1:0]            gnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_id,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic                  state_q, state_d;
  logic                  last_served_q, last_served_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic [1:0]            gnt_q, gnt_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  id_q, id_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  rom_data_unused_s;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  any_req, winner, handshake, start_ok;
  logic [ADDR_WIDTH-1:0] win_start, win_len;

  assign any_req   = req0 | req1;
  assign winner    = (req0 && req1) ? ~last_served_q : (req1 ? REQ1 : REQ0);
  assign win_start = (winner == REQ1) ? start_addr1 : start_addr0;
  assign win_len   = (winner == REQ1) ? len1 : len0;
  assign handshake = valid_q & out_ready;
  assign rom_data_unused_s = 1'b0;

  if (DEPTH < 2**ADDR_WIDTH) begin : g_clamp
    assign start_ok = (win_start < ADDR_WIDTH'(DEPTH));
  end else begin : g_noclamp
    assign start_ok = 1'b1;
  end

  rom #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_rom (
    .addr(ptr_d),
    .data(rom_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_served_q <= REQ1;
      ptr_q         <= '0;
      rem_q         <= '0;
      gnt_q         <= 2'b00;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      id_q          <= 1'b0;
      busy_q        <= 1'b0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      ptr_q         <= ptr_d;
      rem_q         <= rem_d;
      gnt_q         <= gnt_d;
      valid_q       <= valid_d;
      last_q        <= last_d;
      id_q          <= id_d;
      busy_q        <= busy_d;
      data_q        <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = BURST;
        else         state_d = IDLE;
      end
      BURST: begin
        if (handshake && (rem_q == '0)) state_d = IDLE;
        else                            state_d = BURST;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next pointer feeds the ROM address so the new word lands with the register update.
  always_comb begin
    ptr_d = ptr_q;
    rem_d = rem_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          ptr_d = start_ok ? win_start : '0;
          rem_d = win_len;
        end else begin
          ptr_d = ptr_q;
          rem_d = rem_q;
        end
      end
      BURST: begin
        if (handshake && (rem_q != '0)) begin
          ptr_d = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_WIDTH'(1);
          rem_d = rem_q - ADDR_WIDTH'(1);
        end else begin
          ptr_d = ptr_q;
          rem_d = rem_q;
        end
      end
      default: begin
        ptr_d = ptr_q;
        rem_d = rem_q;
      end
    endcase
  end

  always_comb begin
    gnt_d         = 2'b00;
    valid_d       = valid_q;
    last_d        = last_q;
    id_d          = id_q;
    busy_d        = busy_q;
    data_d        = data_q;
    last_served_d = last_served_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d[winner] = 1'b1;
          id_d          = winner;
          data_d        = rom_data;
          valid_d       = 1'b1;
          last_d        = (win_len == '0);
          busy_d        = 1'b1;
        end else begin
          gnt_d = 2'b00;
        end
      end
      BURST: begin
        if (handshake && (rem_q != '0)) begin
          data_d = rom_data;
          last_d = (rem_q == ADDR_WIDTH'(1));
        end else if (handshake) begin
          valid_d       = 1'b0;
          last_d        = 1'b0;
          busy_d        = 1'b0;
          last_served_d = id_q;
        end else begin
          gnt_d = 2'b00;
        end
      end
      default: gnt_d = 2'b00;
    endcase
  end

  assign gnt       = gnt_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_id    = id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed self-checking bench for rom_burst_arbiter (default ROM and a DEPTH=6 variant).
module tb_rom_burst_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1, out_ready;
  logic [2:0] start_addr0, len0, start_addr1, len1;

  logic [1:0] gnt, gnt6;
  logic       out_valid, out_last, out_id, busy;
  logic       out_valid6, out_last6, out_id6, busy6;
  logic [7:0] out_data, out_data6;

  int total = 0;
  int bad   = 0;

  // Packed view: {gnt[1:0], valid, data[7:0], last, id, busy}
  logic [13:0] obs, obs6;
  assign obs  = {gnt,  out_valid,  out_data,  out_last,  out_id,  busy};
  assign obs6 = {gnt6, out_valid6, out_data6, out_last6, out_id6, busy6};

  rom_burst_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .start_addr0(start_addr0), .len0(len0),
    .req1(req1), .start_addr1(start_addr1), .len1(len1),
    .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_id(out_id), .busy(busy)
  );

  rom_burst_arbiter #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .DEPTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .start_addr0(start_addr0), .len0(len0),
    .req1(req1), .start_addr1(start_addr1), .len1(len1),
    .gnt(gnt6), .out_valid(out_valid6), .out_ready(out_ready),
    .out_data(out_data6), .out_last(out_last6), .out_id(out_id6), .busy(busy6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b1;
    start_addr0 = 3'd0; len0 = 3'd0; start_addr1 = 3'd0; len1 = 3'd0;
    #2;
    total++;
    if (obs !== 14'h0) begin bad++; $display("FAIL reset: got %h want %h", obs, 14'h0); end
    total++;
    if (obs6 !== 14'h0) begin bad++; $display("FAIL reset_d6: got %h want %h", obs6, 14'h0); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_burst();
    logic [13:0] exp [4] = '{
      {2'b01, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1},
      {2'b00, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1},
      {2'b00, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1},
      {2'b00, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0}};
    req0 = 1'b1; start_addr0 = 3'd2; len0 = 3'd2; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      req0 = 1'b0;
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL single_burst cyc%0d: got %h want %h", i, obs, exp[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [13:0] exp [5] = '{
      {2'b10, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1},
      {2'b00, 1'b1, 8'h88, 1'b0, 1'b1, 1'b1},
      {2'b00, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1},
      {2'b00, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1},
      {2'b00, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0}};
    req1 = 1'b1; start_addr1 = 3'd6; len1 = 3'd3; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      req1 = 1'b0;
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL wrap cyc%0d: got %h want %h", i, obs, exp[i]); end
    end
  endtask

  task automatic test_arbitration();
    logic [13:0] exp [8] = '{
      {2'b01, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1},
      {2'b00, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0},
      {2'b10, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1},
      {2'b00, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0},
      {2'b01, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1},
      {2'b00, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0},
      {2'b10, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1},
      {2'b00, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0}};
    do_reset();
    start_addr0 = 3'd0; len0 = 3'd0; start_addr1 = 3'd1; len1 = 3'd0; out_ready = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL arbitration cyc%0d: got %h want %h", i, obs, exp[i]); end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [13:0] exp [8] = '{
      {2'b01, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1},
      {2'b00, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1},
      {2'b00, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1},
      {2'b00, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1},
      {2'b00, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1},
      {2'b00, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1},
      {2'b00, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1},
      {2'b00, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0}};
    req0 = 1'b1; start_addr0 = 3'd0; len0 = 3'd3; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      req0 = 1'b0;
      if (i == 3) out_ready = 1'b1;
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL backpressure cyc%0d: got %h want %h", i, obs, exp[i]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [13:0] exp [3] = '{
      {2'b01, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1},
      {2'b00, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1},
      {2'b00, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0}};
    req0 = 1'b1; start_addr0 = 3'd3; len0 = 3'd7; out_ready = 1'b1;
    step();
    req0 = 1'b0;
    step();
    total++;
    if (obs !== {2'b00, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL mid_burst_beat2: got %h want %h", obs, {2'b00, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1});
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 14'h0) begin bad++; $display("FAIL async_reset: got %h want %h", obs, 14'h0); end
    req0 = 1'b1; req1 = 1'b1;
    start_addr0 = 3'd3; len0 = 3'd1; start_addr1 = 3'd5; len1 = 3'd1;
    step();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      req0 = 1'b0; req1 = 1'b0;
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL after_reset cyc%0d: got %h want %h", i, obs, exp[i]); end
    end
  endtask

  task automatic test_full_range();
    logic [7:0] w;
    logic [13:0] e;
    req0 = 1'b1; start_addr0 = 3'd0; len0 = 3'd7; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      req0 = 1'b0;
      w = 8'h11 * 8'(i + 1);
      if (i == 8) e = {2'b00, 1'b0, 8'h88, 1'b0, 1'b0, 1'b0};
      else        e = {(i == 0) ? 2'b01 : 2'b00, 1'b1, w, (i == 7), 1'b0, 1'b1};
      total++;
      if (obs !== e) begin bad++; $display("FAIL full_burst cyc%0d: got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_out_of_range_depth6();
    logic [7:0] seq [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h11, 8'h22};
    logic [13:0] e;
    do_reset();
    req0 = 1'b1; start_addr0 = 3'd7; len0 = 3'd7; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      req0 = 1'b0;
      if (i == 8) e = {2'b00, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0};
      else        e = {(i == 0) ? 2'b01 : 2'b00, 1'b1, seq[i], (i == 7), 1'b0, 1'b1};
      total++;
      if (obs6 !== e) begin bad++; $display("FAIL depth6_wrap cyc%0d: got %h want %h", i, obs6, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_wrap();
    test_arbitration();
    test_backpressure();
    test_reset_mid_burst();
    test_full_range();
    test_out_of_range_depth6();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
